// File: rtl/se_sram_srw_be_clr.sv
// Single-port synchronous SRAM with per-byte-lane writes, a registered read path of
// configurable depth, and a clear engine that fills every word with a constant.
module se_sram_srw_be_clr #(
    parameter int                    address_width  = 14,
    parameter int                    data_width     = 32,
    parameter int                    byte_width     = 8,
    parameter int                    read_pipeline  = 0,
    parameter bit                    clear_on_reset = 1'b1,
    parameter logic [byte_width-1:0] clear_value    = '0
) (
    input  logic                             sram_clock,
    input  logic                             reset_n,
    input  logic                             sram_clock__enable,
    input  logic                             select,
    input  logic                             read_not_write,
    input  logic [data_width/byte_width-1:0] write_enable,
    input  logic [address_width-1:0]         address,
    input  logic [data_width-1:0]            write_data,
    input  logic                             clear_request,
    output logic [data_width-1:0]            data_out,
    output logic                             data_valid,
    output logic                             busy
);
    localparam int LANES = data_width / byte_width;
    localparam int DEPTH = 1 << address_width;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                   state_q;
    logic [address_width-1:0] clr_addr_q;
    logic [data_width-1:0]    mem [DEPTH];

    logic                     enable_ok;
    logic                     access_ok;
    logic                     rd_acc;
    logic                     wr_acc;
    logic                     clr_wr;
    logic [data_width-1:0]    clear_word;

    // Writes are also blocked while reset_n is low, since the array itself is never reset.
    assign enable_ok  = sram_clock__enable && reset_n;
    assign busy       = (state_q == CLEAR);
    assign access_ok  = enable_ok && select && !busy && !clear_request;
    assign rd_acc     = access_ok && read_not_write;
    assign wr_acc     = access_ok && !read_not_write;
    assign clr_wr     = enable_ok && busy;
    assign clear_word = {LANES{clear_value}};

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            if (clear_on_reset) begin
                state_q <= CLEAR;
            end else begin
                state_q <= IDLE;
            end
            clr_addr_q <= '0;
        end else if (sram_clock__enable) begin
            case (state_q)
                IDLE: begin
                    if (clear_request) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + address_width'(1);
                    if (&clr_addr_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sram_clock) begin
        if (clr_wr) begin
            mem[clr_addr_q] <= clear_word;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_enable[i]) begin
                    mem[address][i*byte_width +: byte_width] <= write_data[i*byte_width +: byte_width];
                end
            end
        end
    end

    logic [data_width-1:0] rdata_p0;
    logic                  vld_p0;
    logic [data_width-1:0] rdata_last;
    logic                  vld_last;

    // Stage p0: array fetch
    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_p0 <= '0;
            vld_p0   <= 1'b0;
        end else if (sram_clock__enable) begin
            vld_p0 <= rd_acc;
            if (rd_acc) begin
                rdata_p0 <= mem[address];
            end
        end
    end

    generate
        if (read_pipeline != 0) begin : g_pipe
            logic [data_width-1:0] rdata_p1;
            logic                  vld_p1;

            // Stage p1: optional extra register
            always_ff @(posedge sram_clock or negedge reset_n) begin
                if (!reset_n) begin
                    rdata_p1 <= '0;
                    vld_p1   <= 1'b0;
                end else if (sram_clock__enable) begin
                    vld_p1   <= vld_p0;
                    rdata_p1 <= rdata_p0;
                end
            end

            assign rdata_last = rdata_p1;
            assign vld_last   = vld_p1;
        end else begin : g_nopipe
            assign rdata_last = rdata_p0;
            assign vld_last   = vld_p0;
        end
    endgenerate

    logic [data_width-1:0] data_out_q;
    logic                  data_valid_q;

    // Output stage: data_out only moves on a real result so it holds the last read.
    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else if (sram_clock__enable) begin
            data_valid_q <= vld_last;
            if (vld_last) begin
                data_out_q <= rdata_last;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_se_sram_srw_be_clr.sv
// Bench for se_sram_srw_be_clr: two instances (read_pipeline 0 / fill 0x00 and
// read_pipeline 1 / fill 0xA5) share stimulus and are compared with a timing model.
module tb_se_sram_srw_be_clr;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        sel   = 1'b0;
    logic        rnw   = 1'b0;
    logic        clr   = 1'b0;
    logic [3:0]  we    = '0;
    logic [3:0]  addr  = '0;
    logic [31:0] wd    = '0;
    logic [31:0] dout [2];
    logic        dv   [2];
    logic        bsy  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    se_sram_srw_be_clr #(
        .address_width(AW), .data_width(32), .byte_width(8),
        .read_pipeline(0), .clear_on_reset(1'b1), .clear_value(8'h00)
    ) u0 (
        .sram_clock(clk), .reset_n(rst_n), .sram_clock__enable(en), .select(sel),
        .read_not_write(rnw), .write_enable(we), .address(addr), .write_data(wd),
        .clear_request(clr), .data_out(dout[0]), .data_valid(dv[0]), .busy(bsy[0])
    );

    se_sram_srw_be_clr #(
        .address_width(AW), .data_width(32), .byte_width(8),
        .read_pipeline(1), .clear_on_reset(1'b1), .clear_value(8'hA5)
    ) u1 (
        .sram_clock(clk), .reset_n(rst_n), .sram_clock__enable(en), .select(sel),
        .read_not_write(rnw), .write_enable(we), .address(addr), .write_data(wd),
        .clear_request(clr), .data_out(dout[1]), .data_valid(dv[1]), .busy(bsy[1])
    );

    // Reference model: memory contents, remaining clear writes, and read results
    // scheduled by the enabled-edge count at which they must appear.
    logic [31:0] mmem [2][DEPTH];
    int          clr_left [2];
    logic        sv [2][4];
    logic [31:0] sd [2][4];
    logic [31:0] m_dout [2];
    logic        m_vld [2];
    int          ecnt = 0;

    function automatic logic [7:0] fill_of(input int k);
        return (k == 0) ? 8'h00 : 8'hA5;
    endfunction

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = DEPTH;
            m_dout[k]   = '0;
            m_vld[k]    = 1'b0;
            for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
        end
    endtask

    int slot;
    int tslot;
    bit busy_m;
    bit acc;

    always @(posedge clk) begin
        if (rst_n && en) begin
            ecnt = ecnt + 1;
            for (int k = 0; k < 2; k++) begin
                slot     = ecnt % 4;
                m_vld[k] = sv[k][slot];
                if (sv[k][slot]) m_dout[k] = sd[k][slot];
                sv[k][slot] = 1'b0;
                busy_m = (clr_left[k] > 0);
                acc    = sel && !busy_m && !clr;
                if (acc && rnw) begin
                    tslot        = (ecnt + lat_of(k)) % 4;
                    sv[k][tslot] = 1'b1;
                    sd[k][tslot] = mmem[k][addr];
                end
                if (busy_m) begin
                    mmem[k][DEPTH - clr_left[k]] = {4{fill_of(k)}};
                    clr_left[k] = clr_left[k] - 1;
                end else if (clr) begin
                    clr_left[k] = DEPTH;
                end else if (acc && !rnw) begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) mmem[k][addr][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
    end

    // Apply inputs at a falling edge and return at the next falling edge.
    task automatic drv(input logic e, input logic s, input logic r, input logic [3:0] w,
                       input logic [3:0] a, input logic [31:0] d, input logic c);
        en = e; sel = s; rnw = r; we = w; addr = a; wd = d; clr = c;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== 32'h0 || dv[k] !== 1'b0 || bsy[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_values u%0d: got dout=%h valid=%b busy=%b, want 00000000/0/1", k, dout[k], dv[k], bsy[k]);
            end
        end
        rst_n = 1'b1;
        n = 0;
        while (bsy[0] === 1'b1 && n < 40) begin
            drv(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
            n++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL reset_clear u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d enabled cycles, want 16", n);
        end
    endtask

    task automatic test_read_all();
        int nv0, nv1;
        nv0 = 0; nv1 = 0;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) drv(1'b1, 1'b1, 1'b1, 4'h0, 4'(i), $urandom, 1'b0);
            else        drv(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
            if (dv[0] === 1'b1) nv0++;
            if (dv[1] === 1'b1) nv1++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL read_all u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
        checks++;
        if (nv0 != 16 || nv1 != 16) begin
            errors++;
            $display("FAIL read_all_count: got %0d/%0d valid pulses, want 16/16", nv0, nv1);
        end
    endtask

    task automatic test_byte_lanes();
        drv(1'b1, 1'b1, 1'b0, 4'b1111, 4'd3, 32'hDEADBEEF, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 4'b0101, 4'd3, 32'h11223344, 1'b0);
        drv(1'b1, 1'b1, 1'b1, 4'b0000, 4'd3, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
            checks++;
            if (dv[i] !== 1'b1 || dout[i] !== 32'hDE22BE44) begin
                errors++;
                $display("FAIL byte_lanes u%0d: got %h valid=%b, want DE22BE44 valid=1", i, dout[i], dv[i]);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL byte_lanes_model u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat0, pat1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drv(1'b1, 1'b1, 1'b1, 4'h0, 4'(i), 32'h0, 1'b0);
            else       drv(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
            pat0[i] = dv[0];
            pat1[i] = dv[1];
            if (i >= 2 && i <= 4) begin
                checks++;
                if (dout[1] !== 32'hA5A5A5A5) begin
                    errors++;
                    $display("FAIL b2b_data edge%0d: got %h, want A5A5A5A5", i, dout[1]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL b2b_model u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
        checks++;
        if (pat0 !== 6'b001110 || pat1 !== 6'b011100) begin
            errors++;
            $display("FAIL b2b_valid_pattern: got %b/%b, want 001110/011100", pat0, pat1);
        end
    endtask

    task automatic test_enable_gaps();
        int  n, i;
        logic e;
        drv(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
        n = 0; i = 0;
        while (bsy[0] === 1'b1 && i < 60) begin
            e = !(i >= 5 && i < 8);
            drv(e, 1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
            if (e) n++;
            i++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL gap_clear u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL gap_busy_len: got %0d enabled cycles, want 16", n);
        end
        // Read, stall 3 cycles, one enabled edge, stall 2, then drain.
        for (int j = 0; j < 9; j++) begin
            e = (j == 0 || j == 4 || j >= 7);
            drv(e, (j == 0), 1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
            if (j == 6) begin
                checks++;
                if (dv[0] !== 1'b1 || dout[0] !== 32'h0 || dv[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_read_hold: got u0 %h/%b u1 valid=%b, want 00000000/1 and 0", dout[0], dv[0], dv[1]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL gap_read u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
    endtask

    task automatic test_clear_collision();
        int i;
        drv(1'b1, 1'b1, 1'b0, 4'hF, 4'd5, 32'h12345678, 1'b1);
        i = 0;
        while (bsy[0] === 1'b1 && i < 60) begin
            drv(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 3) == 0));
            i++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL collide_busy u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
        drv(1'b1, 1'b1, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (dout[1] !== 32'hA5A5A5A5 || dv[1] !== 1'b1 || dout[0] !== 32'h0) begin
            errors++;
            $display("FAIL collide_addr5: got u1 %h/%b u0 %h, want A5A5A5A5/1 and 00000000", dout[1], dv[1], dout[0]);
        end
        for (int j = 0; j < 19; j++) begin
            drv(1'b1, (j < 16), 1'b1, 4'h0, 4'(j), 32'h0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL collide_readback u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) drv(1'b1, 1'b1, 1'b1, 4'h0, 4'd2, 32'h0, 1'b0);
            else            repeat (7) drv(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
            drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
            #2 rst_n = 1'b0;
            model_reset();
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== 32'h0 || dv[k] !== 1'b0 || bsy[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL async_reset p%0d u%0d: got %h/%b/%b, want 00000000/0/1", phase, k, dout[k], dv[k], bsy[k]);
                end
            end
            @(negedge clk);
            rst_n = 1'b1;
        end
        n = 0;
        while (bsy[0] === 1'b1 && n < 40) begin
            drv(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
            n++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL reset_restart u%0d: got %h/%b/%b want %h/%b/%b", k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reset_restart_len: got %0d enabled cycles, want 16", n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drv(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 4'($urandom),
                4'($urandom), $urandom, ($urandom_range(0, 79) == 0));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== m_dout[k] || dv[k] !== m_vld[k] || bsy[k] !== (clr_left[k] > 0)) begin
                    errors++;
                    $display("FAIL random cyc%0d u%0d: got %h/%b/%b want %h/%b/%b", i, k, dout[k], dv[k], bsy[k], m_dout[k], m_vld[k], clr_left[k] > 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_byte_lanes();
        test_back_to_back();
        test_enable_gaps();
        test_clear_collision();
        test_reset_midclear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
